// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rf_pkg
// Brief   : Shared sizing constants and types for the register file.
// Revision: 1.0
// ============================================================================
package rf_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 16;

  // Index width for a given depth; a depth of 1 still needs one index bit.
  function automatic int calc_addr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  localparam int DEFAULT_ADDR_W = calc_addr_w(DEFAULT_DEPTH);

  typedef logic [DEFAULT_WIDTH-1:0]  word_t;
  typedef logic [DEFAULT_ADDR_W-1:0] idx_t;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/reg_file_bypass_reg_word.sv
`default_nettype none
// ============================================================================
// Module  : reg_word
// Brief   : One write-enabled storage word with synchronous active-high reset.
// Revision: 1.0
// ============================================================================
module reg_word
  import rf_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (wen) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule : reg_word
`default_nettype wire

// File: rtl/reg_file_bypass.sv
`default_nettype none
// ============================================================================
// Module  : reg_file_bypass
// Brief   : DEPTH x WIDTH register file, two combinational read ports, one
//           write port, optional zero register and write-to-read bypass.
// Revision: 1.0
// ============================================================================
module reg_file_bypass
  import rf_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ADDR_W   = calc_addr_w(DEPTH),
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] src_reg1,
  input  logic [ADDR_W-1:0] src_reg2,
  input  logic [ADDR_W-1:0] dst_reg,
  input  logic              write_reg,
  input  logic [WIDTH-1:0]  dst_data,
  output logic [WIDTH-1:0]  src_data1,
  output logic [WIDTH-1:0]  src_data2
);

  localparam bit C_ZERO_REG = ZERO_REG;
  localparam bit C_BYPASS   = BYPASS;

  logic [WIDTH-1:0] w_q   [DEPTH];
  logic [DEPTH-1:0] w_wen;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_words
      // Register 0 never takes a write when it is the hardwired zero.
      if (C_ZERO_REG && (gi == 0)) begin : g_zero
        assign w_wen[gi] = 1'b0;
      end else begin : g_normal
        assign w_wen[gi] = write_reg & (dst_reg == ADDR_W'(gi)) & ~rst;
      end

      reg_word #(
        .WIDTH (WIDTH)
      ) u_word (
        .clk (clk),
        .rst (rst),
        .wen (w_wen[gi]),
        .d   (dst_data),
        .q   (w_q[gi])
      );
    end
  endgenerate

  logic w_hit1;
  logic w_hit2;

  assign w_hit1 = C_BYPASS & write_reg & (dst_reg == src_reg1);
  assign w_hit2 = C_BYPASS & write_reg & (dst_reg == src_reg2);

  always_comb begin
    src_data1 = w_q[src_reg1];
    src_data2 = w_q[src_reg2];
    if (w_hit1) src_data1 = dst_data;
    if (w_hit2) src_data2 = dst_data;
    if (C_ZERO_REG && (src_reg1 == '0)) src_data1 = '0;
    if (C_ZERO_REG && (src_reg2 == '0)) src_data2 = '0;
    // Reset dominates everything, including a pending bypass match.
    if (rst) begin
      src_data1 = '0;
      src_data2 = '0;
    end
  end

endmodule : reg_file_bypass
`default_nettype wire

// File: tb/tb_reg_file_bypass.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_file_bypass
// Brief   : Self-checking bench for three register file configurations.
// Revision: 1.0
// ============================================================================
module tb_reg_file_bypass;
  import rf_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  src_reg1, src_reg2, dst_reg;
  logic        write_reg;
  logic [15:0] dst_data;
  logic [15:0] o1 [3];
  logic [15:0] o2 [3];

  int vectors;
  int miscompares;

  // Reference state: one 16-entry array per configuration.
  logic [15:0] mem [3][16];

  // cfg 0: defaults, cfg 1: no bypass, cfg 2: zero register
  reg_file_bypass #(.ZERO_REG(1'b0), .BYPASS(1'b1)) u_dut_def (
    .clk(clk), .rst(rst), .src_reg1(src_reg1), .src_reg2(src_reg2),
    .dst_reg(dst_reg), .write_reg(write_reg), .dst_data(dst_data),
    .src_data1(o1[0]), .src_data2(o2[0]));

  reg_file_bypass #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_dut_nobyp (
    .clk(clk), .rst(rst), .src_reg1(src_reg1), .src_reg2(src_reg2),
    .dst_reg(dst_reg), .write_reg(write_reg), .dst_data(dst_data),
    .src_data1(o1[1]), .src_data2(o2[1]));

  reg_file_bypass #(.ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut_zero (
    .clk(clk), .rst(rst), .src_reg1(src_reg1), .src_reg2(src_reg2),
    .dst_reg(dst_reg), .write_reg(write_reg), .dst_data(dst_data),
    .src_data1(o1[2]), .src_data2(o2[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit cfg_zero(input int c);
    return c == 2;
  endfunction

  function automatic bit cfg_byp(input int c);
    return c != 1;
  endfunction

  function automatic logic [15:0] ref_read(input int c, input logic [3:0] s);
    if (rst) return 16'h0000;
    if (cfg_zero(c) && s == 4'd0) return 16'h0000;
    if (cfg_byp(c) && write_reg && dst_reg == s) return dst_data;
    return mem[c][s];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs away from the rising edge, then compare all read ports.
  task automatic drive(input logic r, input logic we, input logic [3:0] d,
                       input logic [15:0] data, input logic [3:0] s1, input logic [3:0] s2);
    @(negedge clk);
    rst = r; write_reg = we; dst_reg = d; dst_data = data;
    src_reg1 = s1; src_reg2 = s2;
    #1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("cfg%0d_p1_r%0d", c, s1), o1[c], ref_read(c, s1));
      check($sformatf("cfg%0d_p2_r%0d", c, s2), o2[c], ref_read(c, s2));
    end
  endtask

  // Advance one edge and update the reference state from the sampled inputs.
  task automatic tick();
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      if (rst) begin
        for (int k = 0; k < 16; k++) mem[c][k] = 16'h0000;
      end else if (write_reg && !(cfg_zero(c) && dst_reg == 4'd0)) begin
        mem[c][dst_reg] = dst_data;
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; write_reg = 1'b0; dst_reg = '0; dst_data = '0;
    src_reg1 = '0; src_reg2 = '0;
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < 16; k++) mem[c][k] = 16'h0000;

    // Initial reset, then random writes, then reset again and read everything.
    drive(1'b1, 1'b0, 4'd0, 16'h0, 4'd0, 4'd1); tick();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, 4'($urandom_range(15)), 16'($urandom), 4'($urandom_range(15)), 4'($urandom_range(15)));
      tick();
    end
    drive(1'b1, 1'b0, 4'd2, 16'h0, 4'd3, 4'd4);
    check("rst_out1", o1[0], 16'h0000);
    check("rst_out2", o2[0], 16'h0000);
    tick();
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b0, 4'd0, 16'h0, 4'(k), 4'(15 - k));
      check("post_rst_all", o1[0], 16'h0000);
      tick();
    end

    // Plain write then read back, neighbours untouched.
    drive(1'b0, 1'b1, 4'd5, 16'hBEEF, 4'd0, 4'd0); tick();
    drive(1'b0, 1'b0, 4'd0, 16'h0, 4'd5, 4'd5);
    check("wr_r5_p1", o1[0], 16'hBEEF);
    check("wr_r5_p2", o2[0], 16'hBEEF);
    tick();
    drive(1'b0, 1'b0, 4'd0, 16'h0, 4'd4, 4'd6);
    check("r4_clear", o1[0], 16'h0000);
    check("r6_clear", o2[0], 16'h0000);
    tick();

    // Bypass versus stored value.
    drive(1'b0, 1'b1, 4'd3, 16'h1111, 4'd0, 4'd1); tick();
    drive(1'b0, 1'b1, 4'd3, 16'h2222, 4'd3, 4'd3);
    check("byp_same_cycle", o1[0], 16'h2222);
    check("nobyp_old_value", o1[1], 16'h1111);
    tick();
    drive(1'b0, 1'b0, 4'd0, 16'h0, 4'd3, 4'd2);
    check("nobyp_next_cycle", o1[1], 16'h2222);
    tick();

    // Write enable low must not change anything.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 4'd7, 16'hFFFF, 4'd7, 4'd7); tick();
    end
    drive(1'b0, 1'b0, 4'd0, 16'h0, 4'd7, 4'd0);
    check("gate_r7", o1[0], 16'h0000);
    tick();

    // Zero register and top index.
    drive(1'b0, 1'b1, 4'd0, 16'hABCD, 4'd0, 4'd0);
    check("zero_same_cycle", o1[2], 16'h0000);
    check("nozero_bypass", o1[0], 16'hABCD);
    tick();
    drive(1'b0, 1'b1, 4'd15, 16'hABCD, 4'd0, 4'd1);
    check("zero_after", o1[2], 16'h0000);
    tick();
    drive(1'b0, 1'b0, 4'd0, 16'h0, 4'd15, 4'd0);
    check("r15_readback", o1[2], 16'hABCD);
    tick();

    // Reset coinciding with a write.
    drive(1'b0, 1'b1, 4'd9, 16'h1234, 4'd0, 4'd0); tick();
    drive(1'b1, 1'b1, 4'd9, 16'h5A5A, 4'd9, 4'd9);
    check("rst_no_bypass", o1[0], 16'h0000);
    tick();
    drive(1'b0, 1'b0, 4'd0, 16'h0, 4'd9, 4'd9);
    check("rst_drops_write", o1[0], 16'h0000);
    tick();

    // Random traffic with index collisions and occasional reset.
    for (int i = 0; i < 300; i++) begin
      logic [3:0] d;
      d = 4'($urandom_range(15));
      drive(($urandom_range(31) == 0), 1'($urandom),  d, 16'($urandom),
            ($urandom_range(3) == 0) ? d : 4'($urandom_range(15)),
            ($urandom_range(3) == 0) ? d : 4'($urandom_range(15)));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_reg_file_bypass
`default_nettype wire
